// File: rtl/klein_cbc_d.sv
// CBC-mode KLEIN-80 decryption front end around a combinational 16-round
// inverse core that is given CALC_CYCLES clock cycles to settle.

module klein_d (
  input  logic [63:0] c,
  input  logic [79:0] key,
  output logic [63:0] p
);
  localparam int NR = 16;

  function automatic logic [3:0] sbox(input logic [3:0] x);
    logic [3:0] y;
    y = 4'h0;
    case (x)
      4'h0: y = 4'h7;
      4'h1: y = 4'h4;
      4'h2: y = 4'hA;
      4'h3: y = 4'h9;
      4'h4: y = 4'h1;
      4'h5: y = 4'hF;
      4'h6: y = 4'hB;
      4'h7: y = 4'h0;
      4'h8: y = 4'hC;
      4'h9: y = 4'h3;
      4'hA: y = 4'h2;
      4'hB: y = 4'hD;
      4'hC: y = 4'h8;
      4'hD: y = 4'hE;
      4'hE: y = 4'h6;
      4'hF: y = 4'h5;
      default: y = 4'h0;
    endcase
    return y;
  endfunction

  function automatic logic [7:0] sbox8(input logic [7:0] x);
    return {sbox(x[7:4]), sbox(x[3:0])};
  endfunction

  // The KLEIN S-box is an involution, so decryption reuses it unchanged.
  function automatic logic [63:0] sub64(input logic [63:0] x);
    logic [63:0] r;
    r = '0;
    for (int i = 0; i < 16; i++) begin
      r[4*i +: 4] = sbox(x[4*i +: 4]);
    end
    return r;
  endfunction

  function automatic logic [7:0] xt(input logic [7:0] x);
    return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [31:0] inv_mix32(input logic [31:0] w);
    logic [7:0] b [4];
    logic [7:0] m9 [4];
    logic [7:0] m11 [4];
    logic [7:0] m13 [4];
    logic [7:0] m14 [4];
    logic [7:0] x2, x4, x8;
    for (int i = 0; i < 4; i++) begin
      b[i]   = w[31-8*i -: 8];
      x2     = xt(b[i]);
      x4     = xt(x2);
      x8     = xt(x4);
      m9[i]  = x8 ^ b[i];
      m11[i] = x8 ^ x2 ^ b[i];
      m13[i] = x8 ^ x4 ^ b[i];
      m14[i] = x8 ^ x4 ^ x2;
    end
    return {m14[0] ^ m11[1] ^ m13[2] ^ m9[3],
            m9[0]  ^ m14[1] ^ m11[2] ^ m13[3],
            m13[0] ^ m9[1]  ^ m14[2] ^ m11[3],
            m11[0] ^ m13[1] ^ m9[2]  ^ m14[3]};
  endfunction

  // Two 5-byte halves rotate left a byte, then (a, b) <- (b, a ^ b).
  function automatic logic [79:0] next_key(input logic [79:0] k, input logic [7:0] rc);
    logic [39:0] a, b, na, nb;
    a  = {k[71:40], k[79:72]};
    b  = {k[31:0], k[39:32]};
    na = b;
    nb = a ^ b;
    na[23:16] = na[23:16] ^ rc;
    nb[31:24] = sbox8(nb[31:24]);
    nb[23:16] = sbox8(nb[23:16]);
    return {na, nb};
  endfunction

  function automatic logic [63:0] dec_round(input logic [63:0] s, input logic [63:0] rk);
    logic [63:0] t;
    t = {inv_mix32(s[63:32]), inv_mix32(s[31:0])};
    t = {t[15:0], t[63:16]};
    return sub64(t) ^ rk;
  endfunction

  for (genvar gi = 0; gi <= NR; gi++) begin : g_key
    logic [79:0] k;
    if (gi == 0) begin : g_first
      assign k = key;
    end else begin : g_next
      assign k = next_key(g_key[gi-1].k, 8'(gi));
    end
  end

  // Rounds are peeled off in reverse, so stage gi consumes stage gi+1.
  for (genvar gi = 0; gi < NR; gi++) begin : g_dec
    logic [63:0] s_in;
    logic [63:0] s_out;
    if (gi == NR - 1) begin : g_last
      assign s_in = c ^ g_key[NR].k[79:16];
    end else begin : g_mid
      assign s_in = g_dec[gi+1].s_out;
    end
    assign s_out = dec_round(s_in, g_key[gi].k[79:16]);
  end

  assign p = g_dec[0].s_out;
endmodule

module klein_cbc_d #(
  parameter int CALC_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        key_load,
  input  logic [79:0] key_in,
  input  logic [63:0] iv_in,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [63:0] in_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [63:0] out_data,
  output logic        busy
);
  localparam logic [3:0] CNT_INIT = 4'(CALC_CYCLES - 1);

  typedef enum logic [1:0] {
    S_NOKEY,
    S_WAIT,
    S_CALC,
    S_OUT
  } state_t;

  state_t      state_reg;
  logic [79:0] key_r;
  logic [63:0] chain_r;
  logic [63:0] c_r;
  logic [3:0]  cnt;
  logic [63:0] core_p;

  // Core inputs only move in WAIT, so they are stable through CALC.
  klein_d u_core (
    .c   (c_r),
    .key (key_r),
    .p   (core_p)
  );

  assign in_ready = (state_reg == S_WAIT) && !key_load;
  assign busy     = (state_reg == S_CALC) || (state_reg == S_OUT);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= S_NOKEY;
      key_r     <= '0;
      chain_r   <= '0;
      c_r       <= '0;
      cnt       <= '0;
      out_data  <= '0;
      out_valid <= 1'b0;
    end else begin
      case (state_reg)
        S_NOKEY: begin
          if (key_load) begin
            key_r     <= key_in;
            chain_r   <= iv_in;
            state_reg <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (key_load) begin
            key_r   <= key_in;
            chain_r <= iv_in;
          end else if (in_valid) begin
            c_r       <= in_data;
            cnt       <= CNT_INIT;
            state_reg <= S_CALC;
          end
        end
        S_CALC: begin
          if (cnt != 4'd0) begin
            cnt <= cnt - 4'd1;
          end else begin
            out_data  <= core_p ^ chain_r;
            chain_r   <= c_r;
            out_valid <= 1'b1;
            state_reg <= S_OUT;
          end
        end
        S_OUT: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state_reg <= S_WAIT;
          end
        end
        default: state_reg <= S_NOKEY;
      endcase
    end
  end
endmodule

// File: tb/tb_klein_cbc_d.sv
// Randomised bench for klein_cbc_d against a byte-level KLEIN-80/CBC model.

module tb_klein_cbc_d;
  localparam int CC = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        key_load = 1'b0;
  logic [79:0] key_in = '0;
  logic [63:0] iv_in = '0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [63:0] in_data = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [63:0] out_data;
  logic        busy;

  int n_vec = 0;
  int n_err = 0;
  int cyc_cnt = 0;

  logic [79:0] m_key;
  logic [63:0] m_chain;

  klein_cbc_d #(.CALC_CYCLES(CC)) dut (
    .clk       (clk),
    .rst       (rst),
    .key_load  (key_load),
    .key_in    (key_in),
    .iv_in     (iv_in),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .busy      (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  // ---------------- reference model ----------------
  localparam logic [3:0] SBOX [16] = '{4'h7, 4'h4, 4'hA, 4'h9, 4'h1, 4'hF, 4'hB, 4'h0,
                                       4'hC, 4'h3, 4'h2, 4'hD, 4'h8, 4'hE, 4'h6, 4'h5};
  localparam logic [7:0] INV_ROW [4] = '{8'd14, 8'd11, 8'd13, 8'd9};

  function automatic logic [7:0] m_sub(input logic [7:0] b);
    return {SBOX[b[7:4]], SBOX[b[3:0]]};
  endfunction

  function automatic logic [7:0] m_gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] r, x;
    logic hi;
    r = '0;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) r = r ^ x;
      hi = x[7];
      x = x << 1;
      if (hi) x = x ^ 8'h1b;
    end
    return r;
  endfunction

  function automatic logic [63:0] model_dec(input logic [63:0] c, input logic [79:0] k);
    logic [7:0] kb [10];
    logic [7:0] t [10];
    logic [63:0] rk [17];
    logic [7:0] s [8];
    logic [7:0] u [8];
    logic [63:0] w;
    for (int i = 0; i < 10; i++) kb[i] = k[79-8*i -: 8];
    for (int r = 0; r <= 16; r++) begin
      for (int i = 0; i < 8; i++) rk[r][63-8*i -: 8] = kb[i];
      for (int j = 0; j < 5; j++) begin
        t[j]   = kb[5 + (j+1)%5];
        t[5+j] = kb[(j+1)%5] ^ kb[5 + (j+1)%5];
      end
      t[2] = t[2] ^ 8'(r + 1);
      t[6] = m_sub(t[6]);
      t[7] = m_sub(t[7]);
      kb = t;
    end
    w = c ^ rk[16];
    for (int i = 0; i < 8; i++) s[i] = w[63-8*i -: 8];
    for (int r = 15; r >= 0; r--) begin
      for (int col = 0; col < 2; col++) begin
        for (int row = 0; row < 4; row++) begin
          u[4*col+row] = '0;
          for (int j = 0; j < 4; j++)
            u[4*col+row] = u[4*col+row] ^ m_gmul(INV_ROW[(j-row+4)%4], s[4*col+j]);
        end
      end
      for (int i = 0; i < 8; i++) s[i] = m_sub(u[(i+6)%8]) ^ rk[r][63-8*i -: 8];
    end
    for (int i = 0; i < 8; i++) w[63-8*i -: 8] = s[i];
    return w;
  endfunction

  // ---------------- drivers ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load_key(input logic [79:0] k, input logic [63:0] iv);
    key_load = 1'b1;
    key_in   = k;
    iv_in    = iv;
    step();
    key_load = 1'b0;
    m_key    = k;
    m_chain  = iv;
  endtask

  task automatic do_accept(input logic [63:0] c, output logic ok, output int acc_cyc);
    ok = 1'b0;
    acc_cyc = 0;
    in_valid = 1'b1;
    in_data  = c;
    for (int i = 0; i < 40 && !ok; i++) begin
      @(negedge clk);
      if (in_ready) begin
        ok = 1'b1;
        acc_cyc = cyc_cnt;
      end
      step();
    end
    in_valid = 1'b0;
    in_data  = {$urandom, $urandom};
  endtask

  task automatic do_output(input int stall, output logic ok, output int edges,
                           output logic [63:0] pdata, output logic stable, output logic vld_after);
    ok = 1'b0;
    edges = 0;
    stable = 1'b1;
    pdata = '0;
    vld_after = 1'b1;
    out_ready = (stall == 0);
    for (int i = 0; i < 60 && !ok; i++) begin
      @(negedge clk);
      if (out_valid) ok = 1'b1;
      else begin
        step();
        edges++;
      end
    end
    if (!ok) begin
      out_ready = 1'b1;
      return;
    end
    pdata = out_data;
    for (int i = 0; i < stall; i++) begin
      step();
      if (i == stall - 1) out_ready = 1'b1;
      @(negedge clk);
      if (!out_valid || out_data !== pdata || in_ready) stable = 1'b0;
    end
    step();
    vld_after = out_valid;
    out_ready = 1'b1;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst = 1'b1;
    in_valid = 1'b1;
    in_data = {$urandom, $urandom};
    repeat (2) step();
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      n_vec++;
      if (in_ready !== 1'b0 || out_valid !== 1'b0 || out_data !== 64'h0 || busy !== 1'b0) begin
        n_err++;
        $display("FAIL reset_nokey cycle %0d: in_ready=%b out_valid=%b out_data=%h busy=%b, want 0 0 0 0",
                 i, in_ready, out_valid, out_data, busy);
      end
      step();
    end
    in_valid = 1'b0;
  endtask

  task automatic run_block(input string tag, input logic [63:0] c, input int stall,
                           input int want_edges, output int acc_cyc);
    logic ok_a, ok_o, stable, vld_after;
    int edges;
    logic [63:0] pdata, exp;
    exp = model_dec(c, m_key) ^ m_chain;
    m_chain = c;
    do_accept(c, ok_a, acc_cyc);
    n_vec++;
    if (ok_a !== 1'b1) begin
      n_err++;
      $display("FAIL %s accept: accepted=%b, want 1", tag, ok_a);
    end
    do_output(stall, ok_o, edges, pdata, stable, vld_after);
    $display("blk %s C=%h P=%h expect=%h stall=%0d", tag, c, pdata, exp, stall);
    n_vec++;
    if (ok_o !== 1'b1 || edges != want_edges) begin
      n_err++;
      $display("FAIL %s latency: out_valid seen=%b after %0d edges, want 1 after %0d", tag, ok_o, edges, want_edges);
    end
    n_vec++;
    if (pdata !== exp) begin
      n_err++;
      $display("FAIL %s data: got %h, want %h", tag, pdata, exp);
    end
    n_vec++;
    if (stable !== 1'b1 || vld_after !== 1'b0) begin
      n_err++;
      $display("FAIL %s hold/drop: stable=%b out_valid_after=%b, want 1 0", tag, stable, vld_after);
    end
  endtask

  task automatic test_single();
    int acc;
    load_key(80'h0123456789ABCDEF0123, 64'h0F0E0D0C0B0A0908);
    run_block("single", 64'h1122334455667788, 0, CC, acc);
  endtask

  task automatic test_back_to_back();
    int acc1, acc2;
    run_block("chain1", 64'hAAAAAAAAAAAAAAAA, 0, CC, acc1);
    run_block("chain2", 64'h5555555555555555, 0, CC, acc2);
    n_vec++;
    if (acc2 - acc1 != CC + 2) begin
      n_err++;
      $display("FAIL chain_interval: got %0d cycles, want %0d", acc2 - acc1, CC + 2);
    end
  endtask

  task automatic test_backpressure();
    logic ok, seen;
    int acc, hs;
    logic [63:0] c, exp;
    c = {$urandom, $urandom};
    exp = model_dec(c, m_key) ^ m_chain;
    m_chain = c;
    out_ready = 1'b0;
    do_accept(c, ok, acc);
    in_valid = 1'b1;
    in_data = {$urandom, $urandom};
    seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      if (out_valid) seen = 1'b1;
      else step();
    end
    n_vec++;
    if (ok !== 1'b1 || seen !== 1'b1) begin
      n_err++;
      $display("FAIL bp_reach_out: accepted=%b out_valid_seen=%b, want 1 1", ok, seen);
    end
    step();
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      n_vec++;
      if (out_valid !== 1'b1 || out_data !== exp || in_ready !== 1'b0) begin
        n_err++;
        $display("FAIL bp_hold cycle %0d: out_valid=%b out_data=%h in_ready=%b, want 1 %h 0",
                 i, out_valid, out_data, in_ready, exp);
      end
      step();
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    hs = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (out_valid && out_ready) hs++;
      step();
    end
    $display("blk bp C=%h handshakes=%0d", c, hs);
    n_vec++;
    if (hs != 1) begin
      n_err++;
      $display("FAIL bp_release: got %0d handshakes, want 1", hs);
    end
    run_block("bp_next", {$urandom, $urandom}, 0, CC, acc);
  endtask

  task automatic test_key_collision();
    int acc;
    logic [79:0] nk;
    nk = {$urandom, $urandom, 16'($urandom)};
    key_load = 1'b1;
    key_in = nk;
    iv_in = 64'h0;
    in_valid = 1'b1;
    in_data = {$urandom, $urandom};
    @(negedge clk);
    n_vec++;
    if (in_ready !== 1'b0) begin
      n_err++;
      $display("FAIL collide_ready: in_ready=%b, want 0", in_ready);
    end
    step();
    key_load = 1'b0;
    in_valid = 1'b0;
    m_key = nk;
    m_chain = 64'h0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      n_vec++;
      if (busy !== 1'b0 || out_valid !== 1'b0) begin
        n_err++;
        $display("FAIL collide_not_taken cycle %0d: busy=%b out_valid=%b, want 0 0", i, busy, out_valid);
      end
      step();
    end
    run_block("newkey", {$urandom, $urandom}, 0, CC, acc);
  endtask

  task automatic test_key_in_calc();
    logic ok_a, ok_o, stable, vld_after;
    int acc, edges;
    logic [63:0] c, exp, pdata;
    c = {$urandom, $urandom};
    exp = model_dec(c, m_key) ^ m_chain;
    m_chain = c;
    do_accept(c, ok_a, acc);
    key_load = 1'b1;
    key_in = {$urandom, $urandom, 16'($urandom)};
    iv_in = {$urandom, $urandom};
    @(negedge clk);
    n_vec++;
    if (busy !== 1'b1) begin
      n_err++;
      $display("FAIL calc_busy: busy=%b, want 1", busy);
    end
    step();
    key_load = 1'b0;
    do_output(0, ok_o, edges, pdata, stable, vld_after);
    $display("blk calc_key C=%h P=%h expect=%h", c, pdata, exp);
    n_vec++;
    if (ok_a !== 1'b1 || ok_o !== 1'b1 || pdata !== exp) begin
      n_err++;
      $display("FAIL calc_key_ignored: acc=%b out=%b got %h, want %h", ok_a, ok_o, pdata, exp);
    end
    run_block("after_calc_key", {$urandom, $urandom}, 0, CC, acc);
  endtask

  task automatic test_random();
    int acc;
    load_key({$urandom, $urandom, 16'($urandom)}, {$urandom, $urandom});
    for (int n = 0; n < 30; n++) begin
      if ($urandom_range(0, 5) == 0) load_key({$urandom, $urandom, 16'($urandom)}, {$urandom, $urandom});
      repeat ($urandom_range(0, 2)) step();
      run_block($sformatf("rnd%0d", n), {$urandom, $urandom}, int'($urandom_range(0, 3)), CC, acc);
    end
  endtask

  task automatic check_dropped(input string tag);
    in_valid = 1'b1;
    in_data = {$urandom, $urandom};
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      n_vec++;
      if (out_valid !== 1'b0 || out_data !== 64'h0 || in_ready !== 1'b0 || busy !== 1'b0) begin
        n_err++;
        $display("FAIL %s cycle %0d: out_valid=%b out_data=%h in_ready=%b busy=%b, want 0 0 0 0",
                 tag, i, out_valid, out_data, in_ready, busy);
      end
      step();
    end
    in_valid = 1'b0;
  endtask

  task automatic test_mid_reset();
    logic ok, seen;
    int acc;
    logic [63:0] c, exp;
    load_key({$urandom, $urandom, 16'($urandom)}, {$urandom, $urandom});
    do_accept({$urandom, $urandom}, ok, acc);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check_dropped("reset_in_calc");
    load_key({$urandom, $urandom, 16'($urandom)}, {$urandom, $urandom});
    c = {$urandom, $urandom};
    exp = model_dec(c, m_key) ^ m_chain;
    out_ready = 1'b0;
    do_accept(c, ok, acc);
    seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      if (out_valid) seen = 1'b1;
      else step();
    end
    n_vec++;
    if (seen !== 1'b1 || out_data !== exp) begin
      n_err++;
      $display("FAIL out_before_reset: seen=%b out_data=%h, want 1 %h", seen, out_data, exp);
    end
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    out_ready = 1'b1;
    check_dropped("reset_in_out");
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_backpressure();
    test_key_collision();
    test_key_in_calc();
    test_random();
    test_mid_reset();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
